// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: keypad entry, code check with failed-attempt lockout,
// auto-relock timer and two-pass code change. All outputs are registered.
module lock_sequencer #(
  parameter int unsigned CLK_HZ       = 5000000,
  parameter int unsigned UNLOCK_SEC   = 5,
  parameter int unsigned ERR_SEC      = 2,
  parameter int unsigned LOCKOUT_SEC  = 30,
  parameter int unsigned MAX_FAIL     = 3,
  parameter logic [15:0] DEFAULT_CODE = 16'h1234
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        newKey,
  input  logic [4:0]  keyCode,
  input  logic        switch,
  output logic        unlock,
  output logic        eLED,
  output logic [15:0] dispVal,
  output logic [3:0]  radixVal
);

  localparam int unsigned   PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_HZ - 1);
  localparam logic [7:0]    UNLOCK_LAST  = 8'(UNLOCK_SEC - 1);
  localparam logic [7:0]    ERR_LAST     = 8'(ERR_SEC - 1);
  localparam logic [7:0]    LOCKOUT_LAST = 8'(LOCKOUT_SEC - 1);
  localparam logic [7:0]    LOCKOUT_TOP  = 8'(LOCKOUT_SEC);
  localparam logic [2:0]    FAIL_LIMIT   = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_UNLOCKED,
    S_NEW1,
    S_NEW2,
    S_ERROR,
    S_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   cand_q, cand_d;
  logic [2:0]    fail_q, fail_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic          err_ret_q, err_ret_d;
  logic          unlock_q, unlock_d;
  logic          eled_q, eled_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    radix_q, radix_d;

  logic          is_digit, is_star, is_hash, is_chg;
  logic          sec_tick;
  logic [2:0]    fail_next;
  logic [3:0]    cnt_mask;

  always_comb begin
    is_digit  = newKey && (keyCode <= 5'd9);
    is_star   = newKey && (keyCode == 5'h0A);
    is_hash   = newKey && (keyCode == 5'h0B);
    is_chg    = newKey && (keyCode == 5'h0C);
    sec_tick  = (presc_q == PRESC_MAX);
    fail_next = fail_q + 3'd1;

    state_d   = state_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    cand_d    = cand_q;
    fail_d    = fail_q;
    err_ret_d = err_ret_q;

    if (sec_tick) begin
      presc_d = '0;
      sec_d   = sec_q + 8'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      sec_d   = sec_q;
    end

    if (state_q == S_LOCKED || state_q == S_NEW1 || state_q == S_NEW2) begin
      if (is_digit && (cnt_q < 3'd4)) begin
        entry_d = {entry_q[11:0], keyCode[3:0]};
        cnt_d   = cnt_q + 3'd1;
      end else if (is_star) begin
        entry_d = '0;
        cnt_d   = '0;
      end
    end

    unique case (state_q)
      S_LOCKED: begin
        presc_d = '0;
        sec_d   = '0;
        if (is_hash) begin
          if (cnt_q == 3'd4) begin
            state_d = S_CHECK;
          end else begin
            fail_d    = fail_next;
            err_ret_d = 1'b0;
            state_d   = (fail_next >= FAIL_LIMIT) ? S_LOCKOUT : S_ERROR;
          end
        end
      end
      S_CHECK: begin
        presc_d = '0;
        sec_d   = '0;
        if (entry_q == code_q) begin
          fail_d  = '0;
          state_d = S_UNLOCKED;
        end else begin
          fail_d    = fail_next;
          err_ret_d = 1'b0;
          state_d   = (fail_next >= FAIL_LIMIT) ? S_LOCKOUT : S_ERROR;
        end
      end
      S_UNLOCKED: begin
        // An open door holds the relock timer at zero, so it restarts on each close.
        if (!switch) begin
          presc_d = '0;
          sec_d   = '0;
        end
        if (is_chg) begin
          state_d = S_NEW1;
        end else if (switch && sec_tick && (sec_q == UNLOCK_LAST)) begin
          state_d = S_LOCKED;
        end
      end
      S_NEW1: begin
        presc_d = '0;
        sec_d   = '0;
        if (is_chg) begin
          state_d = S_UNLOCKED;
        end else if (is_hash) begin
          if (cnt_q == 3'd4) begin
            cand_d  = entry_q;
            state_d = S_NEW2;
          end else begin
            err_ret_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      S_NEW2: begin
        presc_d = '0;
        sec_d   = '0;
        if (is_chg) begin
          state_d = S_UNLOCKED;
        end else if (is_hash) begin
          if ((cnt_q == 3'd4) && (entry_q == cand_q)) begin
            code_d  = entry_q;
            state_d = S_UNLOCKED;
          end else begin
            err_ret_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        if (sec_tick && (sec_q == ERR_LAST)) begin
          state_d = err_ret_q ? S_UNLOCKED : S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (sec_tick && (sec_q == LOCKOUT_LAST)) begin
          fail_d  = '0;
          state_d = S_LOCKED;
        end
      end
      default: state_d = S_LOCKED;
    endcase

    // Every state change restarts the prescaler; only LOCKED->CHECK keeps the entry.
    if (state_d != state_q) begin
      presc_d = '0;
      sec_d   = '0;
      if (!(state_q == S_LOCKED && state_d == S_CHECK)) begin
        entry_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    unique case (cnt_d)
      3'd0:    cnt_mask = 4'b0000;
      3'd1:    cnt_mask = 4'b0001;
      3'd2:    cnt_mask = 4'b0011;
      3'd3:    cnt_mask = 4'b0111;
      default: cnt_mask = 4'b1111;
    endcase

    unlock_d = (state_d == S_UNLOCKED) || (state_d == S_NEW1) || (state_d == S_NEW2) ||
               ((state_d == S_ERROR) && err_ret_d);
    eled_d   = (state_d == S_ERROR) || (state_d == S_LOCKOUT);

    unique case (state_d)
      S_UNLOCKED: begin
        disp_d  = '0;
        radix_d = '1;
      end
      S_ERROR: begin
        disp_d  = 16'hEEEE;
        radix_d = '0;
      end
      S_LOCKOUT: begin
        disp_d  = {8'hEE, LOCKOUT_TOP - sec_d};
        radix_d = '0;
      end
      default: begin
        disp_d  = entry_d;
        radix_d = cnt_mask;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOCKED;
      entry_q   <= '0;
      cnt_q     <= '0;
      code_q    <= DEFAULT_CODE;
      cand_q    <= '0;
      fail_q    <= '0;
      presc_q   <= '0;
      sec_q     <= '0;
      err_ret_q <= 1'b0;
      unlock_q  <= 1'b0;
      eled_q    <= 1'b0;
      disp_q    <= '0;
      radix_q   <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      cand_q    <= cand_d;
      fail_q    <= fail_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      err_ret_q <= err_ret_d;
      unlock_q  <= unlock_d;
      eled_q    <= eled_d;
      disp_q    <= disp_d;
      radix_q   <= radix_d;
    end
  end

  assign unlock   = unlock_q;
  assign eLED     = eled_q;
  assign dispVal  = disp_q;
  assign radixVal = radix_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed scenarios plus random key traffic, checked every
// cycle against a deadline-based behavioural model of the lock.
module tb_lock_sequencer;

  localparam int HZ    = 10;
  localparam int UNL_S = 2;
  localparam int ERR_S = 1;
  localparam int LO_S  = 3;
  localparam int MAXF  = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        newKey;
  logic [4:0]  keyCode;
  logic        switch;
  logic        unlock;
  logic        eLED;
  logic [15:0] dispVal;
  logic [3:0]  radixVal;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sw_cur   = 1'b1;

  // Model: absolute cycle deadlines instead of counters.
  int m_open, m_pass, m_check, m_fails, m_code, m_cand;
  int m_err, m_err_end, m_err_open;
  int m_lock, m_lock_end;
  int m_relock_at;
  int m_dig[$];

  lock_sequencer #(
    .CLK_HZ      (HZ),
    .UNLOCK_SEC  (UNL_S),
    .ERR_SEC     (ERR_S),
    .LOCKOUT_SEC (LO_S),
    .MAX_FAIL    (MAXF),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .newKey  (newKey),
    .keyCode (keyCode),
    .switch  (switch),
    .unlock  (unlock),
    .eLED    (eLED),
    .dispVal (dispVal),
    .radixVal(radixVal)
  );

  always #5 clock = ~clock;

  function automatic int entry_val();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return v;
  endfunction

  function automatic logic [4:0] kcode(input byte ch);
    if (ch == "*") return 5'h0A;
    if (ch == "#") return 5'h0B;
    if (ch == "C") return 5'h0C;
    return 5'(ch - 8'd48);
  endfunction

  task automatic model_reset();
    m_open = 0; m_pass = 0; m_check = 0; m_fails = 0; m_cand = 0;
    m_code = 16'h1234;
    m_err = 0; m_err_end = 0; m_err_open = 0;
    m_lock = 0; m_lock_end = 0; m_relock_at = 0;
    m_dig.delete();
  endtask

  task automatic model_fail(input int c);
    m_fails++;
    m_dig.delete();
    if (m_fails >= MAXF) begin
      m_lock = 1; m_lock_end = c + 1 + LO_S * HZ;
    end else begin
      m_err = 1; m_err_end = c + 1 + ERR_S * HZ; m_err_open = 0;
    end
  endtask

  task automatic model_cc_error(input int c);
    m_pass = 0;
    m_dig.delete();
    m_err = 1; m_err_end = c + 1 + ERR_S * HZ; m_err_open = 1;
  endtask

  // Inputs seen in cycle c determine the lock's condition in cycle c+1.
  task automatic model_step(input bit kv, input int kc, input bit sw);
    int c;
    bit is_d, is_star, is_hash, is_chg;
    c       = cyc;
    is_d    = kv && (kc <= 9);
    is_star = kv && (kc == 10);
    is_hash = kv && (kc == 11);
    is_chg  = kv && (kc == 12);
    if (m_lock != 0) begin
      if (c + 1 == m_lock_end) begin m_lock = 0; m_fails = 0; end
    end else if (m_err != 0) begin
      if (c + 1 == m_err_end) begin
        m_err = 0;
        if (m_err_open != 0) m_relock_at = c + 1 + UNL_S * HZ;
      end
    end else if (m_check != 0) begin
      m_check = 0;
      if (entry_val() == m_code) begin
        m_open = 1; m_fails = 0; m_relock_at = c + 1 + UNL_S * HZ;
        m_dig.delete();
      end else begin
        model_fail(c);
      end
    end else if (m_open != 0 && m_pass == 0) begin
      if (is_chg) begin
        m_pass = 1; m_dig.delete();
      end else if (!sw) begin
        m_relock_at = c + 1 + UNL_S * HZ;
      end else if (c + 1 >= m_relock_at) begin
        m_open = 0;
      end
    end else begin
      if (is_d) begin
        if (m_dig.size() < 4) m_dig.push_back(kc);
      end else if (is_star) begin
        m_dig.delete();
      end else if (is_chg && m_pass != 0) begin
        m_pass = 0; m_dig.delete(); m_relock_at = c + 1 + UNL_S * HZ;
      end else if (is_hash) begin
        if (m_pass == 0) begin
          if (m_dig.size() == 4) m_check = 1;
          else model_fail(c);
        end else if (m_dig.size() != 4) begin
          model_cc_error(c);
        end else if (m_pass == 1) begin
          m_cand = entry_val(); m_pass = 2; m_dig.delete();
        end else if (entry_val() == m_cand) begin
          m_code = m_cand; m_pass = 0; m_dig.delete();
          m_relock_at = c + 1 + UNL_S * HZ;
        end else begin
          model_cc_error(c);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    int eu, ee, ed, er;
    if (m_lock != 0) begin
      eu = 0; ee = 1; er = 0;
      ed = 16'hEE00 + (m_lock_end - cyc + HZ - 1) / HZ;
    end else if (m_err != 0) begin
      eu = m_err_open; ee = 1; ed = 16'hEEEE; er = 0;
    end else if (m_open != 0 && m_pass == 0 && m_check == 0) begin
      eu = 1; ee = 0; ed = 0; er = 15;
    end else begin
      eu = m_open; ee = 0; ed = entry_val(); er = (1 << m_dig.size()) - 1;
    end
    chk("unlock", {15'd0, unlock}, 16'(eu));
    chk("eLED", {15'd0, eLED}, 16'(ee));
    chk("dispVal", dispVal, 16'(ed));
    chk("radixVal", {12'd0, radixVal}, 16'(er));
  endtask

  task automatic step(input bit kv, input logic [4:0] kc, input bit sw);
    newKey  = kv;
    keyCode = kc;
    switch  = sw;
    model_step(kv, int'(kc), sw);
    @(posedge clock);
    #1;
    cyc++;
    newKey = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, sw_cur);
  endtask

  task automatic enter(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, kcode(s[i]), sw_cur);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_unlock"}, {15'd0, unlock}, 16'd0);
    chk({tag, "_eLED"}, {15'd0, eLED}, 16'd0);
    chk({tag, "_dispVal"}, dispVal, 16'd0);
    chk({tag, "_radixVal"}, {12'd0, radixVal}, 16'd0);
  endtask

  // Called one unit after an edge; reset lands mid-cycle and releases just before the next edge.
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1 check_zero_outputs(tag);
    model_reset();
    #4 reset = 1'b0;
  endtask

  initial begin
    bit         kv;
    logic [4:0] kc;
    string      script;
    int         pos;

    reset   = 1'b1;
    newKey  = 1'b0;
    keyCode = '0;
    switch  = 1'b1;
    model_reset();
    #2 check_zero_outputs("reset");
    #2 reset = 1'b0;
    idle(2);

    // Correct code, then relock with the door closed.
    enter("1234");
    chk("entry_1234_disp", dispVal, 16'h1234);
    chk("entry_1234_radix", {12'd0, radixVal}, 16'h000F);
    enter("#");
    idle(25);

    // A fifth digit is dropped; star clears.
    enter("12345");
    chk("fifth_digit_ignored", dispVal, 16'h1234);
    enter("*");

    // Door held open for 100 cycles.
    enter("1234#");
    idle(3);
    sw_cur = 1'b0;
    idle(100);
    sw_cur = 1'b1;
    idle(25);

    // Three failures lead to lockout; keys during lockout are ignored.
    enter("9999#");
    idle(12);
    enter("9999#");
    idle(12);
    enter("9999#");
    enter("1234#C*");
    idle(30);

    // Short entry counts as a failure; a later success clears the count.
    enter("12#");
    idle(12);
    enter("12*1234#");
    idle(24);
    enter("9999#");
    idle(12);
    enter("9999#");
    idle(12);
    enter("1234#");
    idle(24);

    // Code change to 5678.
    enter("1234#");
    idle(2);
    enter("C5678#5678#");
    idle(24);
    enter("1234#");
    idle(12);
    enter("5678#");
    idle(24);

    // Reset in the middle of a lockout.
    enter("0000#");
    idle(12);
    enter("0000#");
    idle(12);
    enter("0000#");
    idle(8);
    async_reset("rst_lockout");
    enter("1234#");
    idle(3);

    // Reset in the middle of the second pass.
    enter("C5678#");
    idle(1);
    async_reset("rst_new2");
    enter("5678#");
    idle(12);
    enter("1234#");
    idle(3);

    // Mismatched second pass keeps the old code.
    enter("C5678#5679#");
    idle(12);
    idle(22);
    enter("1234#");
    idle(24);

    // Random key traffic, biased towards the correct code.
    async_reset("rst_random");
    script = "1234#";
    pos    = 0;
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) sw_cur = ~sw_cur;
      if ($urandom_range(0, 1) == 1) begin
        kc  = kcode(script[pos]);
        pos = (pos + 1) % 5;
      end else begin
        kc = 5'($urandom_range(0, 15));
      end
      step(kv, kc, sw_cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
